glitch_sweep_ctrl: RTL and testbench
====================================

Name: glitch_sweep_ctrl

Overview:
Sequencer sitting in front of the programmable glitch core. Steps a 2-D grid of (delay, width) glitch settings, one attempt per grid point:
- configures and arms the core;
- waits for its completion;
- classifies the target's reaction;
- resets the target and cools down before moving on.
Results are streamed as hit records for the host/UART logger.

Parameters:
DELAY_START, 32'd100, first delay count (core clock cycles)
DELAY_END, 32'd1000, last delay count, inclusive bound
DELAY_STEP, 32'd10, delay increment, must be >= 1
WIDTH_START, 16'd2, first glitch width count
WIDTH_END, 16'd40, last width count, inclusive bound
WIDTH_STEP, 16'd2, width increment, must be >= 1
OBS_TIMEOUT, 32'd204_000, cycles to wait for target verdict
RST_CYCLES, 16'd2040, target reset pulse length
COOL_CYCLES, 32'd20_400, settle time after target reset

Ports:
clk  in  1  core clock (PLL output domain)
reset  in  1  synchronous, active-high
start  in  1  single-cycle pulse; begins sweep from IDLE
abort  in  1  level; forces return to IDLE
core_arm  out  1  single-cycle pulse; core latches delay_cfg/width_cfg and waits for target trigger
core_done  in  1  single-cycle pulse; core finished its glitch pulse
delay_cfg  out  32  current delay setting
width_cfg  out  16  current width setting
target_ok  in  1  target reported normal completion
target_fault  in  1  target reported anomalous output (successful glitch)
target_rst  out  1  target reset, active-high
busy  out  1  high in every state except IDLE/FINISHED
sweep_done  out  1  high in FINISHED
hit_valid  out  1  single-cycle pulse per classified attempt
hit_class  out  2  0=ok, 1=fault, 2=timeout (crash/mute)
hit_delay  out  32  delay of reported attempt
hit_width  out  16  width of reported attempt
attempt_count  out  32  attempts completed, saturating at 32'hFFFF_FFFF

Behaviour:
- Reset: state IDLE, all pulse outputs 0, target_rst 0, busy 0, sweep_done 0, attempt_count 0, delay_cfg=DELAY_START, width_cfg=WIDTH_START, hit_* 0. Reset mid-sweep abandons the attempt immediately.
- States: IDLE, ARM, WAIT_CORE, OBSERVE, REPORT, RESET_TGT, COOLDOWN, NEXT, FINISHED.
- IDLE: on start, load delay_cfg=DELAY_START and width_cfg=WIDTH_START, clear attempt_count, go to ARM.
- ARM: assert core_arm for exactly 1 cycle, go to WAIT_CORE.
- WAIT_CORE: no timeout; waits indefinitely for the target to trigger the core. On core_done, clear the timer and go to OBSERVE.
- OBSERVE: timer counts cycles.
  - target_fault has priority over target_ok when both are high in the same cycle → class 1.
  - Else target_ok → class 0.
  - Else timer reaches OBS_TIMEOUT-1 → class 2.
  - Then go to REPORT.
- REPORT: hit_valid=1 for 1 cycle with hit_class, hit_delay=delay_cfg, hit_width=width_cfg; attempt_count+1 (saturating). Go to RESET_TGT.
- RESET_TGT: target_rst=1 for exactly RST_CYCLES cycles, then COOLDOWN.
- COOLDOWN: COOL_CYCLES cycles with target_rst=0, then NEXT.
- NEXT: width is the inner loop.
  - If width_cfg+WIDTH_STEP > WIDTH_END (computed in 17 bits, no wrap): width_cfg=WIDTH_START and delay advances.
  - If delay_cfg+DELAY_STEP > DELAY_END (computed in 33 bits): go to FINISHED.
  - Else go to ARM. Total latency NEXT→ARM is 1 cycle.
- FINISHED: sweep_done=1; delay_cfg/width_cfg hold last point. start restarts the sweep from the grid origin.
- abort (level): from any non-IDLE state, next cycle → IDLE; target_rst deasserted, no hit_valid emitted, core_arm never issued while abort is high. start is ignored while abort is high.
- start outside IDLE/FINISHED is ignored.
- DELAY_START > DELAY_END or WIDTH_START > WIDTH_END: exactly one attempt at the start point, then FINISHED.

Optional Feature:
GLITCH_STOP_ON_HIT_EN:
- Defined: a class-1 report ends the sweep; REPORT → RESET_TGT → COOLDOWN → FINISHED with delay_cfg/width_cfg holding the successful point.
- Undefined: class 1 is reported and the sweep continues to the end of the grid.

Test Plan:
- Grid DELAY 10..30 step 10, WIDTH 2..4 step 2; core_done 5 cycles after each core_arm; target_ok 3 cycles later → 6 hit_valid pulses in order (10,2),(10,4),(20,2),(20,4),(30,2),(30,4), all class 0; attempt_count=6; sweep_done=1.
- Never assert target_ok/fault after core_done, OBS_TIMEOUT=50 → hit_class=2 exactly 50 cycles after core_done; target_rst high exactly RST_CYCLES cycles.
- target_ok and target_fault asserted in the same cycle at point (20,4) → class 1. With GLITCH_STOP_ON_HIT_EN: FINISHED holding (20,4), attempt_count=4. Without it: 6 reports total.
- abort raised during RESET_TGT → IDLE next cycle, target_rst=0, no further hit_valid or core_arm; new start restarts at (DELAY_START, WIDTH_START).
- Synchronous reset asserted while in OBSERVE → all outputs at reset values next cycle; late target_fault produces no hit_valid.
- DELAY_END=32'hFFFF_FFF0, DELAY_STEP=32'h20 → no wrap-around; FINISHED after the delay=DELAY_START row.

Source files
------------

// File: rtl/glitch_sweep_ctrl.sv
// glitch_sweep_ctrl: steps a (delay, width) grid of glitch settings, one
// attempt per point: arm core, wait for its pulse, classify the target's
// reaction, reset the target, cool down, advance. Each attempt is streamed
// out as a hit record.
// Optional feature macro: GLITCH_STOP_ON_HIT_EN (a fault verdict ends the
// sweep holding the successful point).
module glitch_sweep_ctrl #(
    parameter logic [31:0] DELAY_START = 32'd100,
    parameter logic [31:0] DELAY_END   = 32'd1000,
    parameter logic [31:0] DELAY_STEP  = 32'd10,
    parameter logic [15:0] WIDTH_START = 16'd2,
    parameter logic [15:0] WIDTH_END   = 16'd40,
    parameter logic [15:0] WIDTH_STEP  = 16'd2,
    parameter logic [31:0] OBS_TIMEOUT = 32'd204_000,
    parameter logic [15:0] RST_CYCLES  = 16'd2040,
    parameter logic [31:0] COOL_CYCLES = 32'd20_400
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_abort,
    output logic        o_core_arm,
    input  logic        i_core_done,
    output logic [31:0] o_delay_cfg,
    output logic [15:0] o_width_cfg,
    input  logic        i_target_ok,
    input  logic        i_target_fault,
    output logic        o_target_rst,
    output logic        o_busy,
    output logic        o_sweep_done,
    output logic        o_hit_valid,
    output logic [1:0]  o_hit_class,
    output logic [31:0] o_hit_delay,
    output logic [15:0] o_hit_width,
    output logic [31:0] o_attempt_count
);

    typedef enum logic [3:0] {
        IDLE, ARM, WAIT_CORE, OBSERVE, REPORT, RESET_TGT, COOLDOWN, NEXT, FINISHED
    } state_t;

    state_t      r_state;
    logic [31:0] r_timer;
    logic [31:0] r_delay_cfg;
    logic [15:0] r_width_cfg;
    logic        r_core_arm;
    logic        r_target_rst;
    logic        r_busy;
    logic        r_sweep_done;
    logic        r_hit_valid;
    logic [1:0]  r_hit_class;
    logic [31:0] r_hit_delay;
    logic [15:0] r_hit_width;
    logic [31:0] r_attempt_count;

    // Grid advance computed one bit wider than the setting so it never wraps.
    logic [16:0] w_width_nxt;
    logic [32:0] w_delay_nxt;
    logic        w_width_wrap;
    logic        w_delay_over;
    logic        w_degenerate;
    logic [31:0] w_timer_inc;
    logic        w_obs_last;
    logic        w_rst_last;
    logic        w_cool_last;
    logic        w_decide;
    logic [1:0]  w_verdict;
    logic        w_stop_now;

    assign w_width_nxt  = {1'b0, r_width_cfg} + {1'b0, WIDTH_STEP};
    assign w_delay_nxt  = {1'b0, r_delay_cfg} + {1'b0, DELAY_STEP};
    assign w_width_wrap = w_width_nxt > {1'b0, WIDTH_END};
    assign w_delay_over = w_delay_nxt > {1'b0, DELAY_END};
    assign w_degenerate = (DELAY_START > DELAY_END) || (WIDTH_START > WIDTH_END);

    // Timer compares use ">=" so a zero-length setting still behaves as one cycle.
    assign w_timer_inc  = r_timer + 32'd1;
    assign w_obs_last   = w_timer_inc >= OBS_TIMEOUT;
    assign w_rst_last   = w_timer_inc >= {16'd0, RST_CYCLES};
    assign w_cool_last  = w_timer_inc >= COOL_CYCLES;

    // Fault beats ok when both arrive together; timeout only if neither.
    assign w_decide  = i_target_fault || i_target_ok || w_obs_last;
    assign w_verdict = i_target_fault ? 2'd1 : (i_target_ok ? 2'd0 : 2'd2);

`ifdef GLITCH_STOP_ON_HIT_EN
    logic r_stop;
    assign w_stop_now = r_stop;
`else
    assign w_stop_now = 1'b0;
`endif

    // Sweep sequencer: state, timer, grid position and all registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_timer         <= 32'd0;
            r_delay_cfg     <= DELAY_START;
            r_width_cfg     <= WIDTH_START;
            r_core_arm      <= 1'b0;
            r_target_rst    <= 1'b0;
            r_busy          <= 1'b0;
            r_sweep_done    <= 1'b0;
            r_hit_valid     <= 1'b0;
            r_hit_class     <= 2'd0;
            r_hit_delay     <= 32'd0;
            r_hit_width     <= 16'd0;
            r_attempt_count <= 32'd0;
`ifdef GLITCH_STOP_ON_HIT_EN
            r_stop          <= 1'b0;
`endif
        end else begin
            r_core_arm  <= 1'b0;
            r_hit_valid <= 1'b0;
            if (i_abort && (r_state != IDLE)) begin
                r_state      <= IDLE;
                r_target_rst <= 1'b0;
                r_busy       <= 1'b0;
                r_sweep_done <= 1'b0;
            end else begin
                case (r_state)
                    IDLE, FINISHED: begin
                        if (i_start && !i_abort) begin
                            r_state         <= ARM;
                            r_core_arm      <= 1'b1;
                            r_busy          <= 1'b1;
                            r_sweep_done    <= 1'b0;
                            r_delay_cfg     <= DELAY_START;
                            r_width_cfg     <= WIDTH_START;
                            r_attempt_count <= 32'd0;
`ifdef GLITCH_STOP_ON_HIT_EN
                            r_stop          <= 1'b0;
`endif
                        end
                    end
                    ARM: r_state <= WAIT_CORE;
                    WAIT_CORE: begin
                        if (i_core_done) begin
                            r_timer <= 32'd0;
                            r_state <= OBSERVE;
                        end
                    end
                    OBSERVE: begin
                        if (w_decide) begin
                            r_state     <= REPORT;
                            r_hit_valid <= 1'b1;
                            r_hit_class <= w_verdict;
                            r_hit_delay <= r_delay_cfg;
                            r_hit_width <= r_width_cfg;
                            if (r_attempt_count != 32'hFFFF_FFFF)
                                r_attempt_count <= r_attempt_count + 32'd1;
`ifdef GLITCH_STOP_ON_HIT_EN
                            if (w_verdict == 2'd1)
                                r_stop <= 1'b1;
`endif
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    REPORT: begin
                        r_state      <= RESET_TGT;
                        r_target_rst <= 1'b1;
                        r_timer      <= 32'd0;
                    end
                    RESET_TGT: begin
                        if (w_rst_last) begin
                            r_state      <= COOLDOWN;
                            r_target_rst <= 1'b0;
                            r_timer      <= 32'd0;
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    COOLDOWN: begin
                        if (w_cool_last) begin
                            if (w_stop_now) begin
                                r_state      <= FINISHED;
                                r_busy       <= 1'b0;
                                r_sweep_done <= 1'b1;
                            end else begin
                                r_state <= NEXT;
                            end
                        end else begin
                            r_timer <= w_timer_inc;
                        end
                    end
                    NEXT: begin
                        // Width is the inner loop; the last point is held on finish.
                        if (w_degenerate || (w_width_wrap && w_delay_over)) begin
                            r_state      <= FINISHED;
                            r_busy       <= 1'b0;
                            r_sweep_done <= 1'b1;
                        end else begin
                            r_state    <= ARM;
                            r_core_arm <= 1'b1;
                            if (w_width_wrap) begin
                                r_width_cfg <= WIDTH_START;
                                r_delay_cfg <= w_delay_nxt[31:0];
                            end else begin
                                r_width_cfg <= w_width_nxt[15:0];
                            end
                        end
                    end
                    default: begin
                        r_state      <= IDLE;
                        r_busy       <= 1'b0;
                        r_target_rst <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Pulses are masked by abort so nothing escapes in the cycle abort rises.
    assign o_core_arm      = r_core_arm && !i_abort;
    assign o_hit_valid     = r_hit_valid && !i_abort;
    assign o_delay_cfg     = r_delay_cfg;
    assign o_width_cfg     = r_width_cfg;
    assign o_target_rst    = r_target_rst;
    assign o_busy          = r_busy;
    assign o_sweep_done    = r_sweep_done;
    assign o_hit_class     = r_hit_class;
    assign o_hit_delay     = r_hit_delay;
    assign o_hit_width     = r_hit_width;
    assign o_attempt_count = r_attempt_count;

endmodule

// File: tb/tb_glitch_sweep_ctrl.sv
// Bench for glitch_sweep_ctrl: three instances (small grid, near-overflow
// delay grid, inverted delay range) driven by a core/target responder.
module tb_glitch_sweep_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [2:0]  rst, start, abort, core_done, tok, tfault;
    logic [2:0]  core_arm, target_rst, busy, sweep_done, hit_valid;
    logic [1:0]  hit_class [3];
    logic [31:0] delay_cfg [3];
    logic [31:0] hit_delay [3];
    logic [31:0] attempt   [3];
    logic [15:0] width_cfg [3];
    logic [15:0] hit_width [3];

    glitch_sweep_ctrl #(
        .DELAY_START(32'd10), .DELAY_END(32'd30), .DELAY_STEP(32'd10),
        .WIDTH_START(16'd2), .WIDTH_END(16'd4), .WIDTH_STEP(16'd2),
        .OBS_TIMEOUT(32'd50), .RST_CYCLES(16'd4), .COOL_CYCLES(32'd3)
    ) u_main (
        .i_clk(clk), .i_reset(rst[0]), .i_start(start[0]), .i_abort(abort[0]),
        .o_core_arm(core_arm[0]), .i_core_done(core_done[0]),
        .o_delay_cfg(delay_cfg[0]), .o_width_cfg(width_cfg[0]),
        .i_target_ok(tok[0]), .i_target_fault(tfault[0]),
        .o_target_rst(target_rst[0]), .o_busy(busy[0]), .o_sweep_done(sweep_done[0]),
        .o_hit_valid(hit_valid[0]), .o_hit_class(hit_class[0]),
        .o_hit_delay(hit_delay[0]), .o_hit_width(hit_width[0]),
        .o_attempt_count(attempt[0])
    );

    glitch_sweep_ctrl #(
        .DELAY_START(32'hFFFF_FFE0), .DELAY_END(32'hFFFF_FFF0), .DELAY_STEP(32'h20),
        .WIDTH_START(16'd2), .WIDTH_END(16'd4), .WIDTH_STEP(16'd2),
        .OBS_TIMEOUT(32'd50), .RST_CYCLES(16'd4), .COOL_CYCLES(32'd3)
    ) u_wrap (
        .i_clk(clk), .i_reset(rst[1]), .i_start(start[1]), .i_abort(abort[1]),
        .o_core_arm(core_arm[1]), .i_core_done(core_done[1]),
        .o_delay_cfg(delay_cfg[1]), .o_width_cfg(width_cfg[1]),
        .i_target_ok(tok[1]), .i_target_fault(tfault[1]),
        .o_target_rst(target_rst[1]), .o_busy(busy[1]), .o_sweep_done(sweep_done[1]),
        .o_hit_valid(hit_valid[1]), .o_hit_class(hit_class[1]),
        .o_hit_delay(hit_delay[1]), .o_hit_width(hit_width[1]),
        .o_attempt_count(attempt[1])
    );

    glitch_sweep_ctrl #(
        .DELAY_START(32'd50), .DELAY_END(32'd10), .DELAY_STEP(32'd10),
        .WIDTH_START(16'd2), .WIDTH_END(16'd4), .WIDTH_STEP(16'd2),
        .OBS_TIMEOUT(32'd50), .RST_CYCLES(16'd4), .COOL_CYCLES(32'd3)
    ) u_inv (
        .i_clk(clk), .i_reset(rst[2]), .i_start(start[2]), .i_abort(abort[2]),
        .o_core_arm(core_arm[2]), .i_core_done(core_done[2]),
        .o_delay_cfg(delay_cfg[2]), .o_width_cfg(width_cfg[2]),
        .i_target_ok(tok[2]), .i_target_fault(tfault[2]),
        .o_target_rst(target_rst[2]), .o_busy(busy[2]), .o_sweep_done(sweep_done[2]),
        .o_hit_valid(hit_valid[2]), .o_hit_class(hit_class[2]),
        .o_hit_delay(hit_delay[2]), .o_hit_width(hit_width[2]),
        .o_attempt_count(attempt[2])
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard of expected hit records.
    typedef struct {
        logic [1:0]  cls;
        logic [31:0] d;
        logic [15:0] w;
        logic [31:0] n;
    } rec_t;
    rec_t q[$];
    int cur = 0;
    int hits [3];

    // Responder modes: 0 = ok, 1 = silent target, 2 = ok+fault together at (20,4).
    int       mode    [3];
    logic [2:0] resp_en;
    int       arm_cnt [3];
    int       ok_cnt  [3];

    // Reference walk over a grid, pushing one expected record per attempt.
    task automatic push_grid(input int dut, input int md, input int maxn);
        longint ds, de, dst, d;
        int ws, we, wst, w;
        logic [1:0] cls;
        rec_t e;
        ds = 10; de = 30; dst = 10;
        ws = 2; we = 4; wst = 2;
        if (dut == 1) begin ds = 64'hFFFF_FFE0; de = 64'hFFFF_FFF0; dst = 64'h20; end
        if (dut == 2) begin ds = 50; de = 10; dst = 10; end
        d = ds;
        w = ws;
        for (int n = 1; n <= maxn; n++) begin
            if (md == 1) cls = 2'd2;
            else if (md == 2 && d == 20 && w == 4) cls = 2'd1;
            else cls = 2'd0;
            e.cls = cls;
            e.d   = d[31:0];
            e.w   = w[15:0];
            e.n   = n;
            q.push_back(e);
`ifdef GLITCH_STOP_ON_HIT_EN
            if (cls == 2'd1) return;
`endif
            if (ds > de || ws > we) return;
            if (w + wst > we) begin
                if (d + dst > de) return;
                d = d + dst;
                w = ws;
            end else begin
                w = w + wst;
            end
        end
    endtask

    // Core/target responder: core_done 5 cycles after core_arm, verdict 3 later.
    initial begin
        for (int i = 0; i < 3; i++) begin arm_cnt[i] = 0; ok_cnt[i] = 0; end
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (resp_en[i]) begin
                    core_done[i] = 1'b0;
                    tok[i]       = 1'b0;
                    tfault[i]    = 1'b0;
                    if (ok_cnt[i] > 0) begin
                        ok_cnt[i]--;
                        if (ok_cnt[i] == 0) begin
                            tok[i] = 1'b1;
                            if (mode[i] == 2 && delay_cfg[i] == 32'd20 && width_cfg[i] == 16'd4)
                                tfault[i] = 1'b1;
                        end
                    end
                    if (arm_cnt[i] > 0) begin
                        arm_cnt[i]--;
                        if (arm_cnt[i] == 0) begin
                            core_done[i] = 1'b1;
                            if (mode[i] != 1) ok_cnt[i] = 3;
                        end
                    end
                    if (core_arm[i]) arm_cnt[i] = 5;
                end else begin
                    arm_cnt[i] = 0;
                    ok_cnt[i]  = 0;
                end
            end
        end
    end

    // Output monitor: pops expected records on hit_valid, polices core_arm under abort.
    initial begin
        rec_t e;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                if (hit_valid[i]) begin
                    hits[i]++;
                    if (i != cur || q.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected_hit: dut %0d got class %0d at (%0h,%0h) required none",
                                 i, hit_class[i], hit_delay[i], hit_width[i]);
                    end else begin
                        e = q.pop_front();
                        chk("hit_record", 64'({hit_class[i], hit_delay[i], hit_width[i]}),
                            64'({e.cls, e.d, e.w}));
                        chk("hit_attempts", 64'(attempt[i]), 64'(e.n));
                    end
                end
                if (core_arm[i] && abort[i]) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL arm_during_abort: dut %0d core_arm=1 required 0", i);
                end
            end
        end
    end

    typedef struct {
        int          dut;
        int          md;
        int          exp_reports;
        logic [31:0] exp_delay;
        logic [15:0] exp_width;
    } row_t;
    row_t rows [4];

    task automatic pulse_start(input int i);
        start[i] = 1'b1;
        @(negedge clk);
        start[i] = 1'b0;
    endtask

    initial begin
        int cnt, len, t_done, t_hit;
        logic prev;
        rst = 3'b111; start = '0; abort = '0;
        core_done = '0; tok = '0; tfault = '0;
        resp_en = 3'b111;
        for (int i = 0; i < 3; i++) begin mode[i] = 0; hits[i] = 0; end

        rows[0] = '{0, 0, 6, 32'd30, 16'd4};
`ifdef GLITCH_STOP_ON_HIT_EN
        rows[1] = '{0, 2, 4, 32'd20, 16'd4};
`else
        rows[1] = '{0, 2, 6, 32'd30, 16'd4};
`endif
        rows[2] = '{1, 0, 2, 32'hFFFF_FFE0, 16'd4};
        rows[3] = '{2, 0, 1, 32'd50, 16'd2};

        repeat (3) @(negedge clk);
        chk("rst_busy",      64'(busy[0]), 64'd0);
        chk("rst_done",      64'(sweep_done[0]), 64'd0);
        chk("rst_arm",       64'(core_arm[0]), 64'd0);
        chk("rst_trst",      64'(target_rst[0]), 64'd0);
        chk("rst_hitv",      64'(hit_valid[0]), 64'd0);
        chk("rst_attempts",  64'(attempt[0]), 64'd0);
        chk("rst_delay",     64'(delay_cfg[0]), 64'd10);
        chk("rst_width",     64'(width_cfg[0]), 64'd2);
        chk("rst_delay_wrap", 64'(delay_cfg[1]), 64'hFFFF_FFE0);
        chk("rst_delay_inv", 64'(delay_cfg[2]), 64'd50);
        rst = 3'b000;
        @(negedge clk);

        // Full sweeps, one table row each.
        for (int r = 0; r < 4; r++) begin
            cur = rows[r].dut;
            mode[cur] = rows[r].md;
            hits[cur] = 0;
            q.delete();
            push_grid(cur, rows[r].md, 64);
            pulse_start(cur);
            for (int k = 0; k < 3000 && !sweep_done[cur]; k++) @(negedge clk);
            @(negedge clk);
            chk("row_sweep_done", 64'(sweep_done[cur]), 64'd1);
            chk("row_busy",       64'(busy[cur]), 64'd0);
            chk("row_reports",    64'(hits[cur]), 64'(rows[r].exp_reports));
            chk("row_attempts",   64'(attempt[cur]), 64'(rows[r].exp_reports));
            chk("row_delay_hold", 64'(delay_cfg[cur]), 64'(rows[r].exp_delay));
            chk("row_width_hold", 64'(width_cfg[cur]), 64'(rows[r].exp_width));
            chk("row_queue_empty", 64'(q.size()), 64'd0);
        end

        // Silent target: timeout verdict latency and target reset pulse length.
        cur = 0; mode[0] = 1; q.delete(); hits[0] = 0;
        push_grid(0, 1, 1);
        pulse_start(0);
        t_done = -1000; t_hit = 0;
        for (int k = 0; k < 200 && !core_done[0]; k++) @(negedge clk);
        t_done = cyc;
        for (int k = 0; k < 200 && !hit_valid[0]; k++) @(negedge clk);
        t_hit = cyc;
        chk("timeout_latency", 64'(t_hit - t_done), 64'd51);
        for (int k = 0; k < 20 && !target_rst[0]; k++) @(negedge clk);
        len = 0;
        for (int k = 0; k < 100 && target_rst[0]; k++) begin len++; @(negedge clk); end
        chk("target_rst_len", 64'(len), 64'd4);
        abort[0] = 1'b1;
        @(negedge clk);
        chk("abort_cool_busy", 64'(busy[0]), 64'd0);
        abort[0] = 1'b0;
        repeat (10) @(negedge clk);

        // Abort during the third target reset, then restart from the origin.
        mode[0] = 0; q.delete(); hits[0] = 0;
        push_grid(0, 0, 3);
        pulse_start(0);
        cnt = 0; prev = 1'b0;
        for (int k = 0; k < 2000 && cnt < 3; k++) begin
            @(negedge clk);
            if (target_rst[0] && !prev) cnt++;
            prev = target_rst[0];
        end
        @(negedge clk);
        abort[0] = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy[0]), 64'd0);
        chk("abort_trst", 64'(target_rst[0]), 64'd0);
        chk("abort_done", 64'(sweep_done[0]), 64'd0);
        start[0] = 1'b1;
        repeat (2) @(negedge clk);
        start[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_start_ignored", 64'(busy[0]), 64'd0);
        chk("abort_reports", 64'(hits[0]), 64'd3);
        abort[0] = 1'b0;
        repeat (5) @(negedge clk);
        hits[0] = 0;
        push_grid(0, 0, 64);
        pulse_start(0);
        chk("restart_arm",   64'(core_arm[0]), 64'd1);
        chk("restart_delay", 64'(delay_cfg[0]), 64'd10);
        chk("restart_width", 64'(width_cfg[0]), 64'd2);
        for (int k = 0; k < 3000 && !sweep_done[0]; k++) @(negedge clk);
        @(negedge clk);
        chk("restart_reports", 64'(hits[0]), 64'd6);

        // Synchronous reset while observing the third attempt; a late fault is ignored.
        q.delete(); hits[0] = 0;
        push_grid(0, 0, 2);
        pulse_start(0);
        cnt = 0;
        for (int k = 0; k < 2000 && cnt < 3; k++) begin
            @(negedge clk);
            if (core_done[0]) cnt++;
        end
        @(negedge clk);
        chk("obs_pre_busy",     64'(busy[0]), 64'd1);
        chk("obs_pre_attempts", 64'(attempt[0]), 64'd2);
        resp_en[0] = 1'b0;
        core_done[0] = 1'b0; tok[0] = 1'b0; tfault[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        rst[0] = 1'b0;
        chk("srst_busy",     64'(busy[0]), 64'd0);
        chk("srst_attempts", 64'(attempt[0]), 64'd0);
        chk("srst_delay",    64'(delay_cfg[0]), 64'd10);
        chk("srst_width",    64'(width_cfg[0]), 64'd2);
        chk("srst_hit_rec",  64'({hit_class[0], hit_delay[0], hit_width[0]}), 64'd0);
        chk("srst_pulses",   64'({core_arm[0], target_rst[0], hit_valid[0], sweep_done[0]}), 64'd0);
        tfault[0] = 1'b1;
        repeat (3) @(negedge clk);
        tfault[0] = 1'b0;
        repeat (20) @(negedge clk);
        chk("srst_no_hit", 64'(hits[0]), 64'd2);
        resp_en[0] = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
